// File: rtl/snake_tile_renderer.sv
// Tiled snake playfield renderer: fills a ping-pong row buffer from the segment
// stream while the other half is displayed. Optional macro: SNAKE_TILE_RENDER_FLASH_EN.
module snake_tile_renderer #(
  parameter int unsigned GRID_W    = 18,
  parameter int unsigned GRID_H    = 13,
  parameter int unsigned TILE_LOG2 = 5,
  parameter int unsigned CBITS     = 2,
  parameter int unsigned SHADES    = 3,
  localparam int unsigned XW       = $clog2(GRID_W + 2),
  localparam int unsigned YW       = $clog2(GRID_H + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       px,
  input  logic [8:0]       py,
  input  logic             visible,
  input  logic             line_start,
  input  logic             frame_start,
  input  logic [XW-1:0]    apple_x,
  input  logic [YW-1:0]    apple_y,
  input  logic             apple_valid,
  input  logic [XW-1:0]    head_x,
  input  logic [YW-1:0]    head_y,
  input  logic             head_valid,
  input  logic [XW-1:0]    seg_x,
  input  logic [YW-1:0]    seg_y,
  input  logic             seg_first,
  input  logic             seg_last,
  input  logic             seg_valid,
  output logic             seg_ready,
  input  logic             failure,
  input  logic             success,
  output logic [CBITS-1:0] r,
  output logic [CBITS-1:0] g,
  output logic [CBITS-1:0] b,
  output logic             overrun
);

  localparam int unsigned SW = $clog2(SHADES + 1);
  localparam int unsigned BW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam logic [CBITS-1:0] CMAX  = {CBITS{1'b1}};
  localparam logic [CBITS-1:0] CHALF = CBITS'(1) << (CBITS - 1);

  typedef enum logic [1:0] {CLEAR, FILL, DONE} state_e;

  state_e         state_q;
  logic [BW-1:0]  clr_idx_q;
  logic           init_q;
  logic           disp_sel_q;
  logic [YW-1:0]  fill_row_q;
  logic [SW-1:0]  shade_q;
  logic           seg_ready_q;
  logic           overrun_q;
  logic [SW-1:0]  buf_q [2][GRID_W];

  logic [CBITS-1:0] r_q, g_q, b_q;
  logic [CBITS-1:0] r_d, g_d, b_d;

  logic           swap_c;
  logic           hs_c;
  logic           seg_hit_c;
  logic [SW-1:0]  seg_shade_c;
  logic [SW-1:0]  shade_d;

  assign swap_c = frame_start | (line_start & (&py[TILE_LOG2-1:0]));
  assign hs_c   = seg_valid & seg_ready_q;

  // Segment lands in the fill buffer only on the target row and inside the grid.
  assign seg_hit_c = (seg_y == fill_row_q) &&
                     (32'(seg_x) >= 32'd1) && (32'(seg_x) <= GRID_W);

  assign seg_shade_c = seg_first ? SW'(1) : shade_q;
  assign shade_d     = (32'(seg_shade_c) >= SHADES) ? SW'(1) : SW'(seg_shade_c + SW'(1));

  // Fill FSM, buffer clearing/writes and swap handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_idx_q   <= '0;
      init_q      <= 1'b1;
      disp_sel_q  <= 1'b0;
      fill_row_q  <= '0;
      shade_q     <= SW'(1);
      seg_ready_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (swap_c) begin
      // A concurrent segment handshake is dropped here on purpose.
      if (state_q != DONE) overrun_q <= 1'b1;
      disp_sel_q  <= ~disp_sel_q;
      state_q     <= CLEAR;
      clr_idx_q   <= '0;
      init_q      <= 1'b0;
      seg_ready_q <= 1'b0;
      if (frame_start) fill_row_q <= YW'(1);
      else             fill_row_q <= YW'(32'(py >> TILE_LOG2) + 32'd2);
    end else begin
      case (state_q)
        CLEAR: begin
          buf_q[~disp_sel_q][clr_idx_q] <= '0;
          if (init_q) buf_q[disp_sel_q][clr_idx_q] <= '0;
          if (32'(clr_idx_q) >= GRID_W - 1) begin
            state_q     <= init_q ? DONE : FILL;
            seg_ready_q <= ~init_q;
            init_q      <= 1'b0;
            clr_idx_q   <= '0;
          end else begin
            clr_idx_q <= clr_idx_q + BW'(1);
          end
        end
        FILL: begin
          if (hs_c) begin
            if (seg_hit_c) buf_q[~disp_sel_q][BW'(seg_x - XW'(1))] <= seg_shade_c;
            shade_q <= shade_d;
            if (seg_last) begin
              state_q     <= DONE;
              seg_ready_q <= 1'b0;
            end
          end
        end
        default: seg_ready_q <= 1'b0;
      endcase
    end
  end

`ifdef SNAKE_TILE_RENDER_FLASH_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)              frame_cnt_q <= '0;
    else if (frame_start) frame_cnt_q <= frame_cnt_q + 8'd1;
  end

  logic [CBITS-1:0] bd_r_c, bd_g_c, bd_b_c;
  always_comb begin
    bd_r_c = CMAX;
    bd_g_c = CMAX;
    bd_b_c = CMAX;
    if (failure) begin
      bd_r_c = frame_cnt_q[4] ? CMAX : '0;
      bd_g_c = '0;
      bd_b_c = '0;
    end else if (success) begin
      bd_r_c = '0;
      bd_g_c = CMAX;
      bd_b_c = '0;
    end
  end
`else
  logic [CBITS-1:0] bd_r_c, bd_g_c, bd_b_c;
  logic             unused_status;
  assign bd_r_c        = CMAX;
  assign bd_g_c        = CMAX;
  assign bd_b_c        = CMAX;
  assign unused_status = failure ^ success;
`endif

  logic [9:0]    tx_c, ty_c;
  logic          in_grid_x_c;
  logic [BW-1:0] body_idx_c;
  logic [SW-1:0] ent_c;
  logic          unused_px;

  assign tx_c        = 10'(px >> TILE_LOG2);
  assign ty_c        = 10'(py >> TILE_LOG2);
  assign unused_px   = ^px[TILE_LOG2-1:0];
  assign in_grid_x_c = (32'(tx_c) >= 32'd1) && (32'(tx_c) <= GRID_W);
  assign body_idx_c  = in_grid_x_c ? BW'(tx_c - 10'd1) : '0;
  assign ent_c       = buf_q[disp_sel_q][body_idx_c];

  // Colour priority: blank, head, border, off-grid, apple, body.
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (!visible) begin
      r_d = '0;
    end else if (head_valid && tx_c == 10'(head_x) && ty_c == 10'(head_y)) begin
      r_d = CHALF;
      g_d = CHALF;
    end else if (tx_c == 10'd0 || 32'(tx_c) == GRID_W + 1 ||
                 ty_c == 10'd0 || 32'(ty_c) == GRID_H + 1) begin
      r_d = bd_r_c;
      g_d = bd_g_c;
      b_d = bd_b_c;
    end else if (32'(tx_c) > GRID_W + 1 || 32'(ty_c) > GRID_H + 1) begin
      r_d = '0;
    end else if (apple_valid && tx_c == 10'(apple_x) && ty_c == 10'(apple_y)) begin
      r_d = CMAX;
    end else if (ent_c != '0) begin
      g_d = CBITS'(ent_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  assign r         = r_q;
  assign g         = g_q;
  assign b         = b_q;
  assign overrun   = overrun_q;
  assign seg_ready = seg_ready_q;

endmodule
